// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
// Module      : layer_compositor
// Description : Per-pixel priority compositor and layer scheduler for the
//               breakout video path. Up to four painters (border, bricks,
//               paddle, ball) each present a hit flag and a 6-bit colour. The
//               lowest-index enabled painter that hits wins the pixel.
//               Layer enables change only at the start of a frame, and a
//               frame-counted flash effect blinks one chosen layer.
//               All outputs are registered one cycle after their inputs.
//
// Ports       :
//   clk           in   pixel clock (hpos/vpos advance one per cycle)
//   rst           in   synchronous, active-high reset
//   hpos          in   current column [9:0]
//   vpos          in   current row [8:0]
//   display_on    in   high inside the visible area
//   hsync_in      in   horizontal sync from the sync generator
//   vsync_in      in   vertical sync from the sync generator
//   layer_hit     in   bit i high when painter i covers the pixel
//   layer_color   in   colour of painter i in bits [6i+5:6i]
//   cfg_en_we     in   write strobe for the pending layer-enable mask
//   cfg_en_data   in   new enable mask, bit i enables layer i
//   flash_req     in   one-cycle pulse that starts/retriggers a flash
//   rgb           out  registered pixel colour, BBGGRR
//   hsync_out     out  hsync_in delayed by one cycle
//   vsync_out     out  vsync_in delayed by one cycle
//   frame_start   out  one-cycle pulse at pixel (0,0), registered
//   flash_active  out  high while the flash FSM is in FLASH
//   win_valid     out  high when an enabled layer won the pixel
//   win_idx       out  index of the winning layer, 0 when win_valid is low
//
// Revision    : 1.0 - initial release
// ============================================================================
module layer_compositor #(
    parameter int          NUM_LAYERS   = 4,
    parameter logic [5:0]  BG_COLOR     = 6'b000000,
    parameter int          FLASH_FRAMES = 8,
    parameter int          FLASH_LAYER  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                hpos,
    input  logic [8:0]                vpos,
    input  logic                      display_on,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic [NUM_LAYERS-1:0]     layer_hit,
    input  logic [6*NUM_LAYERS-1:0]   layer_color,
    input  logic                      cfg_en_we,
    input  logic [NUM_LAYERS-1:0]     cfg_en_data,
    input  logic                      flash_req,
    output logic [5:0]                rgb,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      frame_start,
    output logic                      flash_active,
    output logic                      win_valid,
    output logic [1:0]                win_idx
);

    localparam logic [7:0] C_FLASH_RELOAD = 8'(FLASH_FRAMES);
    localparam logic [1:0] C_FLASH_IDX    = 2'(FLASH_LAYER);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLASH = 1'b1
    } flash_state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_LAYERS-1:0] r_en_pending;
    logic [NUM_LAYERS-1:0] r_en_active;
    flash_state_t          r_state;
    logic [7:0]            r_flash_cnt;

    // ------------------------------------------------------------------------
    // Combinational selection
    // ------------------------------------------------------------------------
    logic       w_fs;
    logic       w_win;
    logic [1:0] w_idx;
    logic [5:0] w_color;
    logic [5:0] w_pixel;

    assign w_fs = (hpos == 10'd0) && (vpos == 9'd0);

    // Scan from the lowest-priority layer upward so the last assignment that
    // sticks belongs to the lowest index, i.e. the highest-priority hit.
    always_comb begin
        w_win   = 1'b0;
        w_idx   = 2'd0;
        w_color = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_hit[i] && r_en_active[i]) begin
                w_win   = 1'b1;
                w_idx   = 2'(i);
                w_color = layer_color[6*i +: 6];
            end
        end
    end

    // Flash blink: invert the flash layer on odd counts so it toggles once per
    // frame while the flash runs.
    always_comb begin
        w_pixel = w_color;
        if (w_win && (w_idx == C_FLASH_IDX) && (r_state == ST_FLASH) &&
            r_flash_cnt[0]) begin
            w_pixel = ~w_color;
        end
    end

    // ------------------------------------------------------------------------
    // Layer-enable masks: the active mask only moves at frame start so a
    // configuration write never tears the picture mid-frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_pending <= {NUM_LAYERS{1'b1}};
            r_en_active  <= {NUM_LAYERS{1'b1}};
        end else begin
            if (cfg_en_we) begin
                r_en_pending <= cfg_en_data;
            end
            if (w_fs) begin
                // A write landing on the frame-start cycle takes effect now.
                r_en_active <= cfg_en_we ? cfg_en_data : r_en_pending;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Flash FSM. A retrigger reloads the counter and wins over a same-cycle
    // frame decrement; the count never goes below zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_flash_cnt  <= 8'd0;
            flash_active <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (flash_req) begin
                        r_state      <= ST_FLASH;
                        r_flash_cnt  <= C_FLASH_RELOAD;
                        flash_active <= 1'b1;
                    end
                end
                ST_FLASH: begin
                    if (flash_req) begin
                        r_flash_cnt  <= C_FLASH_RELOAD;
                        flash_active <= 1'b1;
                    end else if (w_fs) begin
                        if (r_flash_cnt > 8'd1) begin
                            r_flash_cnt <= r_flash_cnt - 8'd1;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_flash_cnt  <= 8'd0;
                            flash_active <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_flash_cnt  <= 8'd0;
                    flash_active <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb         <= 6'b000000;
            hsync_out   <= 1'b0;
            vsync_out   <= 1'b0;
            frame_start <= 1'b0;
            win_valid   <= 1'b0;
            win_idx     <= 2'd0;
        end else begin
            hsync_out   <= hsync_in;
            vsync_out   <= vsync_in;
            frame_start <= w_fs;
            if (!display_on) begin
                // Blanking forces black regardless of any painter.
                rgb       <= 6'b000000;
                win_valid <= 1'b0;
                win_idx   <= 2'd0;
            end else begin
                rgb       <= w_pixel;
                win_valid <= w_win;
                win_idx   <= w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_compositor
// Description : Directed self-checking bench for layer_compositor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hpos;
    logic [8:0]  vpos;
    logic        display_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [3:0]  layer_hit;
    logic [23:0] layer_color;
    logic        cfg_en_we;
    logic [3:0]  cfg_en_data;
    logic        flash_req;
    logic [5:0]  rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        frame_start;
    logic        flash_active;
    logic        win_valid;
    logic [1:0]  win_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    layer_compositor #(
        .NUM_LAYERS   (4),
        .BG_COLOR     (6'b000000),
        .FLASH_FRAMES (8),
        .FLASH_LAYER  (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hpos         (hpos),
        .vpos         (vpos),
        .display_on   (display_on),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .layer_hit    (layer_hit),
        .layer_color  (layer_color),
        .cfg_en_we    (cfg_en_we),
        .cfg_en_data  (cfg_en_data),
        .flash_req    (flash_req),
        .rgb          (rgb),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .frame_start  (frame_start),
        .flash_active (flash_active),
        .win_valid    (win_valid),
        .win_idx      (win_idx)
    );

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Colours: L0=0x3F, L1=0x0C, L2=0x15, L3=0x30
        rst         = 1'b1;
        hpos        = 10'd5;
        vpos        = 9'd5;
        display_on  = 1'b1;
        hsync_in    = 1'b0;
        vsync_in    = 1'b0;
        layer_hit   = 4'b0000;
        layer_color = {6'h30, 6'h15, 6'h0C, 6'h3F};
        cfg_en_we   = 1'b0;
        cfg_en_data = 4'b0000;
        flash_req   = 1'b0;
        tick();
        tick();
        chk("rst_rgb",        8'(rgb),          8'h00);
        chk("rst_hsync",      8'(hsync_out),    8'h0);
        chk("rst_vsync",      8'(vsync_out),    8'h0);
        chk("rst_fs",         8'(frame_start),  8'h0);
        chk("rst_flash",      8'(flash_active), 8'h0);
        chk("rst_win_valid",  8'(win_valid),    8'h0);
        chk("rst_win_idx",    8'(win_idx),      8'h0);

        // Background and sync delay
        rst      = 1'b0;
        hsync_in = 1'b1;
        tick();
        chk("bg_rgb",       8'(rgb),       8'h00);
        chk("bg_win_valid", 8'(win_valid), 8'h0);
        chk("hsync_d1",     8'(hsync_out), 8'h1);
        chk("vsync_d1",     8'(vsync_out), 8'h0);
        hsync_in = 1'b0;
        vsync_in = 1'b1;
        tick();
        chk("hsync_d2", 8'(hsync_out), 8'h0);
        chk("vsync_d2", 8'(vsync_out), 8'h1);
        vsync_in = 1'b0;

        // Priority: layers 1 and 3 hit, layer 1 wins
        layer_hit = 4'b1010;
        tick();
        chk("prio_rgb",   8'(rgb),       8'h0C);
        chk("prio_idx",   8'(win_idx),   8'h1);
        chk("prio_valid", 8'(win_valid), 8'h1);

        // Blanking
        display_on = 1'b0;
        tick();
        chk("blank_rgb",   8'(rgb),       8'h00);
        chk("blank_valid", 8'(win_valid), 8'h0);
        chk("blank_idx",   8'(win_idx),   8'h0);
        display_on = 1'b1;

        // Mid-frame enable write (disable layer 1): no effect until fs
        cfg_en_we   = 1'b1;
        cfg_en_data = 4'b1101;
        tick();
        chk("mid_we_rgb", 8'(rgb), 8'h0C);
        cfg_en_we = 1'b0;
        tick();
        chk("mid_hold_rgb", 8'(rgb), 8'h0C);
        chk("mid_hold_fs",  8'(frame_start), 8'h0);
        hpos = 10'd0;
        vpos = 9'd0;
        tick();
        chk("fs_pixel_rgb", 8'(rgb),         8'h0C);
        chk("fs_pulse",     8'(frame_start), 8'h1);
        hpos = 10'd1;
        tick();
        chk("new_mask_rgb", 8'(rgb),         8'h30);
        chk("new_mask_idx", 8'(win_idx),     8'h3);
        chk("fs_once",      8'(frame_start), 8'h0);

        // Enable write coincident with fs: layer 0 disabled immediately
        layer_hit   = 4'b0011;
        hpos        = 10'd0;
        cfg_en_we   = 1'b1;
        cfg_en_data = 4'b1110;
        tick();
        chk("coin_fs_rgb", 8'(rgb),     8'h3F);
        chk("coin_fs_idx", 8'(win_idx), 8'h0);
        hpos      = 10'd1;
        cfg_en_we = 1'b0;
        tick();
        chk("coin_after_rgb", 8'(rgb),     8'h0C);
        chk("coin_after_idx", 8'(win_idx), 8'h1);

        // Re-enable everything at next fs; only layer 0 hits (still disabled now)
        layer_hit   = 4'b0001;
        hpos        = 10'd0;
        cfg_en_we   = 1'b1;
        cfg_en_data = 4'b1111;
        tick();
        chk("dis_l0_rgb",   8'(rgb),       8'h00);
        chk("dis_l0_valid", 8'(win_valid), 8'h0);
        hpos      = 10'd1;
        cfg_en_we = 1'b0;
        tick();
        chk("reen_rgb", 8'(rgb), 8'h3F);

        // Flash: 8 frames, blink on odd counts
        flash_req = 1'b1;
        tick();
        chk("flash_start_act", 8'(flash_active), 8'h1);
        flash_req = 1'b0;
        tick();
        chk("flash_cnt8_rgb", 8'(rgb), 8'h3F);
        for (int k = 1; k <= 8; k++) begin
            hpos = 10'd0;
            tick();
            chk("flash_fs_pulse", 8'(frame_start),  8'h1);
            chk("flash_act",      8'(flash_active), (k < 8) ? 8'h1 : 8'h0);
            hpos = 10'd1;
            tick();
            // Count after frame k is 8-k; odd counts invert 0x3F to 0x00.
            chk("flash_rgb", 8'(rgb), (k < 8 && ((8 - k) % 2 == 1)) ? 8'h00 : 8'h3F);
        end

        // Retrigger on the fs cycle where the count is 1
        flash_req = 1'b1;
        tick();
        flash_req = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            hpos = 10'd0;
            tick();
            hpos = 10'd1;
            tick();
        end
        hpos      = 10'd0;
        flash_req = 1'b1;
        tick();
        chk("retrig_act", 8'(flash_active), 8'h1);
        hpos      = 10'd1;
        flash_req = 1'b0;
        tick();
        chk("retrig_cnt8_rgb", 8'(rgb),          8'h3F);
        chk("retrig_act2",     8'(flash_active), 8'h1);
        hpos = 10'd0;
        tick();
        hpos = 10'd1;
        tick();
        chk("retrig_cnt7_rgb", 8'(rgb), 8'h00);

        // Reset in the middle of a flash
        rst = 1'b1;
        tick();
        chk("rst_flash_act", 8'(flash_active), 8'h0);
        chk("rst_flash_rgb", 8'(rgb),          8'h00);
        rst = 1'b0;
        tick();
        chk("post_rst_rgb", 8'(rgb),          8'h3F);
        chk("post_rst_act", 8'(flash_active), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Per-pixel priority compositor and layer scheduler for the breakout video path.
- Takes in-region flags and 6-bit colours from up to four painters (border, bricks, paddle, ball) and picks the winning layer. Each painter drives a hit flag plus a constant or computed colour.
- Applies frame-synchronous layer enables and a frame-counted flash effect.
- Drives a registered BBGGRR pixel and delay-matched syncs to the output pins.

Parameters:
- NUM_LAYERS, 4, number of painter layers (1..4); index 0 has highest priority.
- BG_COLOR, 6'b000000, colour shown where no enabled layer hits.
- FLASH_FRAMES, 8, frames a flash lasts after trigger (1..255).
- FLASH_LAYER, 0, layer index whose colour is modulated during a flash.

Ports:
- clk  in  1  pixel clock; hpos/vpos advance one per cycle.
- rst  in  1  synchronous, active-high reset.
- hpos  in  10  current column from sync generator.
- vpos  in  9  current row from sync generator.
- display_on  in  1  high in visible area.
- hsync_in  in  1  horizontal sync from sync generator.
- vsync_in  in  1  vertical sync from sync generator.
- layer_hit  in  NUM_LAYERS  bit i high when painter i covers the pixel.
- layer_color  in  6*NUM_LAYERS  colour of painter i in bits [6i+5:6i].
- cfg_en_we  in  1  write strobe for the layer enable mask.
- cfg_en_data  in  NUM_LAYERS  new enable mask; bit i enables layer i.
- flash_req  in  1  one-cycle pulse that starts or retriggers a flash.
- rgb  out  6  registered pixel colour, BBGGRR.
- hsync_out  out  1  hsync_in delayed 1 cycle.
- vsync_out  out  1  vsync_in delayed 1 cycle.
- frame_start  out  1  registered 1-cycle pulse, one per frame.
- flash_active  out  1  high while the flash FSM is in FLASH.
- win_valid  out  1  registered; high when an enabled layer won the pixel.
- win_idx  out  2  registered index of the winning layer; 0 when win_valid is low.

Behaviour:
- Reset values: rgb=0, hsync_out=0, vsync_out=0, frame_start=0, flash_active=0, win_valid=0, win_idx=0.
- Reset also sets the active and pending enable masks to all ones, the flash FSM to IDLE and flash_cnt to 0.
- Reset asserted mid-frame or mid-flash aborts everything immediately on the next edge.
- Latency: exactly 1 cycle from inputs to rgb/win_*/sync outputs. All outputs are registered; there is no combinational input-to-output path.
- fs (internal, combinational) = (hpos==0 && vpos==0). frame_start is fs registered.
- Enable masks:
  - cfg_en_we loads the pending mask.
  - On an fs cycle, the active mask takes the pending mask.
  - If cfg_en_we and fs coincide, the active mask takes cfg_en_data directly.
  - The active mask never changes outside fs, so there is no mid-frame tearing.
- Selection: winner = lowest index i with layer_hit[i] and active[i].
  - Colour = layer_color[i], except as modified by the flash below.
  - No winner -> BG_COLOR, win_valid=0.
- Flash modulation: when the winner is FLASH_LAYER, the FSM is in FLASH and flash_cnt[0]==1, the colour is bitwise inverted. The layer therefore blinks at half frame rate.
- Blanking: when display_on=0, rgb is registered as 6'b000000 and win_valid as 0, overriding all other colour logic.
- Flash FSM, states IDLE and FLASH:
  - IDLE, flash_req=1 -> FLASH, flash_cnt=FLASH_FRAMES.
  - FLASH, flash_req=1 -> stay in FLASH, flash_cnt reloads to FLASH_FRAMES. Retrigger has priority over an fs decrement in the same cycle.
  - FLASH, fs and flash_cnt>1 -> flash_cnt-1.
  - FLASH, fs and flash_cnt==1 -> IDLE, flash_cnt=0.
  - flash_active = (state==FLASH), registered with the state.
- flash_cnt is 8 bits and never wraps below 0.
- win_idx is 2 bits regardless of NUM_LAYERS; layers absent from the configuration never win.

Test Plan:
- Reset, then all layer_hit=0 with display_on=1 -> rgb=BG_COLOR (0x00) one cycle later; win_valid=0; syncs track the inputs with 1-cycle delay.
- layer_hit=4'b1010, colours L1=0x0C, L3=0x30 -> rgb=0x0C, win_idx=1; then drop display_on -> rgb=0x00 on the next cycle.
- Mid-frame cfg_en_we with data 4'b1101 while layer 1 hits -> rgb stays L1 until fs; after fs, L3 wins (0x30) and frame_start pulses exactly once.
- cfg_en_we coincident with fs, data 4'b1110 -> layer 0 is disabled from that frame on; layer 1 wins where both hit.
- flash_req with FLASH_FRAMES=8 and layer 0 (0x3F) hitting -> flash_active=1 for 8 frame_start pulses, then 0. rgb alternates 0x3F/0x00 per frame (cnt 8 normal, 7 inverted, ...).
- flash_req on the same cycle as fs with flash_cnt==1 -> stays in FLASH, cnt=8. Separately, rst asserted during FLASH -> flash_active=0 and rgb=0 on the next edge.
